alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 102 ++++++++++
 tb/tb_alu_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: grants one of two requesters access to a shared combinational 24-bit ALU and returns its result
module alu_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [1:0]  req0_op,
    input  logic [23:0] req0_a,
    input  logic [23:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_op,
    input  logic [23:0] req1_a,
    input  logic [23:0] req1_b,
    output logic        req1_ready,
    output logic [1:0]  alu_op,
    output logic [23:0] alu_a,
    output logic [23:0] alu_b,
    input  logic [23:0] alu_r,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [23:0] rsp_r,
    input  logic        rsp_ready,
    output logic        busy,
    output logic [7:0]  done_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [23:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic        id_q, id_d, rid_q, rid_d, last_q, last_d;
    logic [7:0]  done_q, done_d;
    logic        gnt, grant_ok;
    // Under contention round-robin picks whoever was not granted last time.
    assign gnt        = (req0_valid && req1_valid) ? (FIXED_PRIO ? 1'b0 : ~last_q) : req1_valid;
    assign grant_ok   = rst_n && (state_q == IDLE);
    assign req0_ready = grant_ok && req0_valid && !gnt;
    assign req1_ready = grant_ok && req1_valid && gnt;
    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rid_q;
    assign rsp_r      = r_q;
    assign busy       = (state_q != IDLE);
    assign done_cnt   = done_q;
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        last_d  = last_q;
        r_d     = r_q;
        rid_d   = rid_q;
        done_d  = done_q;
        case (state_q)
            IDLE: if (req0_valid || req1_valid) begin
                state_d = EXEC;
                op_d    = gnt ? req1_op : req0_op;
                a_d     = gnt ? req1_a : req0_a;
                b_d     = gnt ? req1_b : req0_b;
                id_d    = gnt;
                last_d  = gnt;
            end
            EXEC: begin
                state_d = RESP;
                r_d     = alu_r;
                rid_d   = id_q;
            end
            RESP: if (rsp_ready) begin
                state_d = IDLE;
                done_d  = done_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            r_q     <= '0;
            rid_q   <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            last_q  <= last_d;
            r_q     <= r_d;
            rid_q   <= rid_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: round-robin and fixed-priority instances driven in lockstep, checked against a transaction model
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v0, v1, rsp_ready;
    logic [1:0]  op0, op1;
    logic [23:0] a0, b0, a1, b1;
    logic [1:0]  r0rdy, r1rdy, rvalid, rid, busy;
    logic [1:0][1:0]  aop;
    logic [1:0][23:0] aa, bb, ar, rr;
    logic [1:0][7:0]  dc;
    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [23:0] alu(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a & b;
            2'd2:    return (b >= 24'd24) ? 24'd0 : a >> b;
            default: return (b >= 24'd24) ? 24'd0 : a << b;
        endcase
    endfunction

    assign ar[0] = alu(aop[0], aa[0], bb[0]);
    assign ar[1] = alu(aop[1], aa[1], bb[1]);

    alu_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_op(op0), .req0_a(a0), .req0_b(b0), .req0_ready(r0rdy[0]),
        .req1_valid(v1), .req1_op(op1), .req1_a(a1), .req1_b(b1), .req1_ready(r1rdy[0]),
        .alu_op(aop[0]), .alu_a(aa[0]), .alu_b(bb[0]), .alu_r(ar[0]),
        .rsp_valid(rvalid[0]), .rsp_id(rid[0]), .rsp_r(rr[0]), .rsp_ready(rsp_ready),
        .busy(busy[0]), .done_cnt(dc[0])
    );

    alu_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_op(op0), .req0_a(a0), .req0_b(b0), .req0_ready(r0rdy[1]),
        .req1_valid(v1), .req1_op(op1), .req1_a(a1), .req1_b(b1), .req1_ready(r1rdy[1]),
        .alu_op(aop[1]), .alu_a(aa[1]), .alu_b(bb[1]), .alu_r(ar[1]),
        .rsp_valid(rvalid[1]), .rsp_id(rid[1]), .rsp_r(rr[1]), .rsp_ready(rsp_ready),
        .busy(busy[1]), .done_cnt(dc[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: age 0 = free, 1 = accepted last edge, 2 = result owed to consumer.
    int          m_age[2];
    logic        m_last[2];
    logic        m_id[2];
    logic [7:0]  m_done[2];
    logic [23:0] m_res[2];

    function automatic logic winner(input int k);
        return (v0 && v1) ? ((k == 1) ? 1'b0 : ~m_last[k]) : v1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_age[k]  <= 0;
                m_last[k] <= 1'b1;
                m_id[k]   <= 1'b0;
                m_done[k] <= 8'd0;
                m_res[k]  <= 24'd0;
            end else if (m_age[k] == 0) begin
                if (v0 || v1) begin
                    m_age[k]  <= 1;
                    m_last[k] <= winner(k);
                    m_id[k]   <= winner(k);
                    m_res[k]  <= winner(k) ? alu(op1, a1, b1) : alu(op0, a0, b0);
                end
            end else if (m_age[k] == 1) begin
                m_age[k] <= 2;
            end else if (rsp_ready) begin
                m_age[k]  <= 0;
                m_done[k] <= m_done[k] + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("req0_ready[%0d]", k), r0rdy[k], rst_n && m_age[k] == 0 && v0 && !winner(k));
            chk($sformatf("req1_ready[%0d]", k), r1rdy[k], rst_n && m_age[k] == 0 && v1 && winner(k));
            chk($sformatf("rsp_valid[%0d]", k), rvalid[k], m_age[k] == 2);
            chk($sformatf("busy[%0d]", k), busy[k], m_age[k] != 0);
            chk($sformatf("done_cnt[%0d]", k), dc[k], m_done[k]);
            if (m_age[k] == 2) begin
                chk($sformatf("rsp_r[%0d]", k), rr[k], m_res[k]);
                chk($sformatf("rsp_id[%0d]", k), rid[k], m_id[k]);
            end
        end
    end

    int gq0[$];
    int gq1[$];
    always @(negedge clk) begin
        if (r0rdy[0]) gq0.push_back(0);
        if (r1rdy[0]) gq0.push_back(1);
        if (r0rdy[1]) gq1.push_back(0);
        if (r1rdy[1]) gq1.push_back(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    int exp_rr[4] = '{0, 1, 0, 1};

    initial begin
        v0 = 1'b1; v1 = 1'b0; rsp_ready = 1'b1;
        op0 = 2'd0; op1 = 2'd0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #12;
        chk("ready_in_reset", r0rdy[0], 1'b0);
        v0 = 1'b0;
        #11 rst_n = 1'b1;
        step;
        chk("reset_rsp_valid", rvalid[0], 1'b0);
        chk("reset_busy", busy[0], 1'b0);
        chk("reset_done", dc[0], 8'd0);
        chk("reset_alu_a", aa[0], 24'd0);

        // add wrap
        op0 = 2'd0; a0 = 24'hFFFFFF; b0 = 24'h000001; v0 = 1'b1;
        #1 chk("add_ready", r0rdy[0], 1'b1);
        step; v0 = 1'b0;
        #1 chk("add_exec_busy", busy[0], 1'b1);
        chk("add_exec_novalid", rvalid[0], 1'b0);
        step;
        #1 chk("add_rsp_valid", rvalid[0], 1'b1);
        chk("add_rsp_r", rr[0], 24'h000000);
        chk("add_rsp_id", rid[0], 1'b0);
        step;
        #1 chk("add_done", dc[0], 8'd1);

        // shift right by 24 and shift left by 23
        op1 = 2'd2; a1 = 24'h800000; b1 = 24'd24; v1 = 1'b1;
        #1 chk("shr_ready", r1rdy[0], 1'b1);
        step; v1 = 1'b0;
        step;
        #1 chk("shr_rsp_r", rr[0], 24'h000000);
        chk("shr_rsp_id", rid[0], 1'b1);
        step;
        op1 = 2'd3; a1 = 24'h000001; b1 = 24'd23; v1 = 1'b1;
        step; v1 = 1'b0;
        step;
        #1 chk("shl_rsp_r", rr[0], 24'h800000);
        step;

        // continuous contention
        op0 = 2'd0; a0 = 24'd1; b0 = 24'd2;
        op1 = 2'd1; a1 = 24'h00FF00; b1 = 24'h0F0F0F;
        gq0.delete(); gq1.delete();
        v0 = 1'b1; v1 = 1'b1;
        repeat (12) step;
        v0 = 1'b0; v1 = 1'b0;
        #1 chk("rr_grant_count", gq0.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_grant_%0d", i), gq0[i], exp_rr[i]);
        chk("fp_grant_count", gq1.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("fp_grant_%0d", i), gq1[i], 0);
        chk("rr_done_after_12", dc[0], 8'd7);
        chk("fp_done_after_12", dc[1], 8'd7);

        // AND with consumer back-pressure; req1 arrives while busy
        op0 = 2'd1; a0 = 24'hF0F0F0; b0 = 24'h0FF0FF; v0 = 1'b1; rsp_ready = 1'b0;
        #1 chk("and_ready", r0rdy[0], 1'b1);
        step; v0 = 1'b0;
        op1 = 2'd0; a1 = 24'd5; b1 = 24'd7; v1 = 1'b1;
        step;
        for (int i = 0; i < 5; i++) begin
            #1 chk("and_hold_valid", rvalid[0], 1'b1);
            chk("and_hold_r", rr[0], 24'h00F0F0);
            chk("and_hold_busy", busy[0], 1'b1);
            chk("and_hold_noready", r1rdy[0], 1'b0);
            step;
        end
        rsp_ready = 1'b1;
        step;
        #1 chk("waiting_req1_ready", r1rdy[0], 1'b1);
        step; v1 = 1'b0;
        step;
        #1 chk("waiting_req1_r", rr[0], 24'h00000C);
        step;
        #1 chk("and_done", dc[0], 8'd9);

        // reset in EXEC
        op0 = 2'd0; a0 = 24'd1; b0 = 24'd1; v0 = 1'b1;
        step;
        rst_n = 1'b0;
        #1 chk("rst_exec_valid", rvalid[0], 1'b0);
        chk("rst_exec_busy", busy[0], 1'b0);
        chk("rst_exec_done", dc[0], 8'd0);
        chk("rst_exec_alu_a", aa[0], 24'd0);
        chk("rst_exec_ready", r0rdy[0], 1'b0);
        v0 = 1'b0;
        #2 rst_n = 1'b1;
        op0 = 2'd0; a0 = 24'd3; b0 = 24'd4; v0 = 1'b1;
        op1 = 2'd0; a1 = 24'd5; b1 = 24'd7; v1 = 1'b1;
        #1 chk("post_rst_req0_wins", r0rdy[0], 1'b1);
        chk("post_rst_req1_waits", r1rdy[0], 1'b0);
        step; v0 = 1'b0;
        step;
        #1 chk("post_rst_rsp_r", rr[0], 24'd7);
        chk("post_rst_rsp_id", rid[0], 1'b0);
        step;
        step; v1 = 1'b0;
        step;
        #1 chk("post_rst_rsp_r1", rr[0], 24'd12);
        step;
        #1 chk("post_rst_done", dc[0], 8'd2);

        // done_cnt wrap
        op0 = 2'd0; a0 = 24'd9; b0 = 24'd1; v0 = 1'b1;
        repeat (3 * 260) step;
        v0 = 1'b0;
        #1 chk("done_wrap", dc[0], 8'd6);
        step;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
